// File: rtl/pipe_pkg.sv
// Shared definitions for the execute-stage iterative multiply/divide unit:
// FSM state encoding, step mode, rstatus exception codes and parameter defaults.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } md_mode_t;

  // rstatus codes written on exception, shared with the ALU overflow path
  localparam int unsigned EXC_MUL = 4;
  localparam int unsigned EXC_DIV = 5;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_TAG_W = 5;

endpackage

// File: rtl/pipe_multdiv_step.sv
// One combinational iteration of the multiply/divide datapath: add-shift for
// multiply, trial-subtract-shift (restoring) for divide, on unsigned magnitudes.
module md_step
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  md_mode_t           mode,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] trial;

  // Multiply: upper half accumulates, low half holds the unconsumed multiplier.
  // Divide: upper half is the partial remainder, low half shifts dividend out / quotient in.
  always_comb begin
    mul_sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
    trial   = acc_in[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
    acc_out = '0;
    if (mode == MODE_MUL) begin
      acc_out = {mul_sum, acc_in[WIDTH-1:1]};
    end else if (trial[WIDTH]) begin
      acc_out = {acc_in[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/pipe_multdiv.sv
// Iterative signed multiply/divide unit for the execute stage: one operation in
// flight, pipeline held via stall, tagged result with an overflow/div-by-zero flag.
module pipe_multdiv
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int TAG_W = DEFAULT_TAG_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             result_rdy,
  output logic [TAG_W-1:0] tag_out
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_t          state, next_state;
  md_mode_t           step_mode;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] acc, step_acc, prod;
  logic [WIDTH-1:0]   operand_reg, mag_a, mag_b, quot;
  logic [WIDTH-1:0]   final_result;
  logic               final_exc;
  logic               res_neg, div_zero;
  logic [TAG_W-1:0]   op_tag;
  logic               accept, last_step, b_zero;

  assign mag_a     = operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign mag_b     = operand_b[WIDTH-1] ? -operand_b : operand_b;
  assign b_zero    = (operand_b == '0);
  assign accept    = (state == IDLE || state == DONE) && (start_mult || start_div) && !flush && reset;
  assign last_step = (count == '0);
  assign step_mode = (state == DIV) ? MODE_DIV : MODE_MUL;

  md_step #(.WIDTH(WIDTH)) u_step (
    .mode    (step_mode),
    .acc_in  (acc),
    .operand (operand_reg),
    .acc_out (step_acc)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, DONE: next_state = accept ? (start_mult ? MULT : DIV) : IDLE;
      MULT, DIV:  if (last_step) next_state = DONE;
      default:    next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  always_comb begin
    busy       = (state == MULT) || (state == DIV);
    stall      = busy || accept;
    result_rdy = (state == DONE);
  end

  // Sign is applied only on the final step, to the value the step is producing.
  always_comb begin
    prod         = res_neg ? -step_acc : step_acc;
    quot         = res_neg ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
    final_result = '0;
    final_exc    = 1'b0;
    if (state == MULT) begin
      final_result = prod[WIDTH-1:0];
      final_exc    = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
    end else if (div_zero) begin
      final_exc    = 1'b1;
    end else begin
      final_result = quot;
      final_exc    = !res_neg && step_acc[WIDTH-1];
    end
  end

  // Divide by zero still passes through DIV for one edge, with the counter preset to zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count       <= '0;
      acc         <= '0;
      operand_reg <= '0;
      res_neg     <= 1'b0;
      div_zero    <= 1'b0;
      op_tag      <= '0;
      result      <= '0;
      exception   <= 1'b0;
      tag_out     <= '0;
    end else if (accept) begin
      acc         <= {{WIDTH{1'b0}}, start_mult ? mag_b : mag_a};
      operand_reg <= start_mult ? mag_a : mag_b;
      res_neg     <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
      div_zero    <= !start_mult && b_zero;
      op_tag      <= tag_in;
      count       <= (!start_mult && b_zero) ? '0 : CNT_W'(WIDTH - 1);
    end else if (busy && !flush) begin
      acc   <= step_acc;
      count <= count - 1'b1;
      if (last_step) begin
        result    <= final_result;
        exception <= final_exc;
        tag_out   <= op_tag;
      end
    end
  end

endmodule

// File: tb/tb_pipe_multdiv.sv
// Self-checking bench for pipe_multdiv: directed cases pinned to literals, then
// random traffic compared every cycle against a cycle-level behavioural model.
module tb_pipe_multdiv;
  import pipe_pkg::*;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start_mult = 1'b0, start_div = 1'b0, flush = 1'b0;
  logic [W-1:0]  operand_a = '0, operand_b = '0;
  logic [4:0]    tag_in = '0;
  logic          busy, stall, exception, result_rdy;
  logic [W-1:0]  result;
  logic [4:0]    tag_out;

  int errors = 0;
  int checks = 0;

  // Model state: what has completed, and what is in flight with its due edge.
  int           edges = 0;
  bit           m_inflight = 1'b0, m_rdy = 1'b0, m_exc = 1'b0, p_exc = 1'b0;
  int           m_done_edge = 0;
  logic [W-1:0] m_res = '0, p_res = '0;
  logic [4:0]   m_tag = '0, p_tag = '0;

  pipe_multdiv #(.WIDTH(W), .TAG_W(5)) dut (
    .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .operand_a(operand_a), .operand_b(operand_b), .tag_in(tag_in), .flush(flush),
    .busy(busy), .stall(stall), .result(result), .exception(exception),
    .result_rdy(result_rdy), .tag_out(tag_out)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish (actual=running required=finished)");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_op(input bit mul, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] res, output bit exc);
    longint p;
    int     sa, sb;
    if (mul) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      res = p[W-1:0];
      exc = (p != longint'($signed(p[W-1:0])));
    end else if (b == 0) begin
      res = '0;
      exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      res = 32'h8000_0000;
      exc = 1'b1;
    end else begin
      sa  = a;
      sb  = b;
      res = sa / sb;
      exc = 1'b0;
    end
  endfunction

  always @(posedge clock) begin
    edges++;
    m_rdy = 1'b0;
    if (!reset) begin
      m_inflight = 1'b0;
      m_res = '0; m_exc = 1'b0; m_tag = '0;
    end else if (flush) begin
      m_inflight = 1'b0;
    end else if (m_inflight) begin
      if (edges == m_done_edge) begin
        m_res = p_res; m_exc = p_exc; m_tag = p_tag;
        m_rdy = 1'b1;
        m_inflight = 1'b0;
      end
    end else if (start_mult || start_div) begin
      model_op(start_mult, operand_a, operand_b, p_res, p_exc);
      p_tag       = tag_in;
      m_done_edge = edges + ((!start_mult && operand_b == 0) ? 1 : W);
      m_inflight  = 1'b1;
    end
  end

  always @(negedge clock) begin
    check_output("busy", busy, m_inflight);
    check_output("stall", stall, m_inflight || ((start_mult || start_div) && !flush && reset));
    check_output("result_rdy", result_rdy, m_rdy);
    check_output("result", result, m_res);
    check_output("exception", exception, m_exc);
    check_output("tag_out", tag_out, m_tag);
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_rdy(input int exp_lat, input string name);
    int lat = -1;
    for (int i = 0; i <= W + 8; i++) begin
      @(negedge clock);
      if (result_rdy) begin
        lat = i;
        break;
      end
    end
    check_output({name, "_latency"}, lat, exp_lat);
  endtask

  task automatic apply_stimulus(input bit mul, input bit both, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [4:0] tag, input logic [W-1:0] exp_res, input bit exp_exc,
                                input int exp_lat, input string name);
    logic [W-1:0] mr;
    bit           me;
    model_op(mul || both, a, b, mr, me);
    check_output({name, "_model_res"}, mr, exp_res);
    check_output({name, "_model_exc"}, me, exp_exc);
    start_mult = mul || both;
    start_div  = !mul || both;
    operand_a  = a;
    operand_b  = b;
    tag_in     = tag;
    tick();
    start_mult = 1'b0;
    start_div  = 1'b0;
    wait_rdy(exp_lat, name);
    check_output({name, "_res"}, result, exp_res);
    check_output({name, "_exc"}, exception, exp_exc);
    check_output({name, "_tag"}, tag_out, tag);
    tick();
  endtask

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h7FFF_FFFF;
      4:       v = W'($urandom_range(0, 20)) - W'(10);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    bit seen;
    $display("[TB] rstatus codes mul=%0d div=%0d", EXC_MUL, EXC_DIV);
    repeat (3) tick();
    check_output("reset_result", result, 0);
    check_output("reset_busy", busy, 0);
    reset = 1'b1;
    tick();

    apply_stimulus(1, 0, 32'd6, 32'd7, 5'd3, 32'd42, 0, W, "mul_6x7");
    apply_stimulus(0, 0, -32'sd7, 32'd2, 5'd4, 32'hFFFF_FFFD, 0, W, "div_m7_2");
    apply_stimulus(0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 32'h8000_0000, 1, W, "div_ovf");
    apply_stimulus(0, 0, 32'd9, 32'd0, 5'd6, 32'd0, 1, 1, "div_zero");
    apply_stimulus(1, 0, 32'h7FFF_FFFF, 32'd2, 5'd7, 32'hFFFF_FFFE, 1, W, "mul_ovf");
    apply_stimulus(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'd1, 0, W, "mul_m1_m1");
    apply_stimulus(0, 1, 32'd5, 32'd3, 5'd9, 32'd15, 0, W, "both_starts");

    // Flush mid-divide with a competing start on the same edge
    start_div = 1'b1; operand_a = 32'd100; operand_b = 32'd7; tag_in = 5'd10;
    tick();
    start_div = 1'b0;
    repeat (9) tick();
    flush = 1'b1; start_div = 1'b1;
    tick();
    flush = 1'b0; start_div = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clock);
      if (result_rdy) seen = 1'b1;
    end
    check_output("flush_no_rdy", seen, 0);
    check_output("flush_res_held", result, 32'd15);
    check_output("flush_tag_held", tag_out, 5'd9);
    tick();

    // Back-to-back: second start presented in the DONE cycle
    start_mult = 1'b1; operand_a = 32'd3; operand_b = 32'd4; tag_in = 5'd11;
    tick();
    start_mult = 1'b0;
    wait_rdy(W, "b2b_first");
    check_output("b2b_first_res", result, 32'd12);
    #1;
    start_mult = 1'b1; operand_a = -32'sd3; operand_b = 32'd5; tag_in = 5'd12;
    @(posedge clock);
    #2;
    start_mult = 1'b0;
    wait_rdy(W, "b2b_second");
    check_output("b2b_second_res", result, 32'hFFFF_FFF1);
    check_output("b2b_second_tag", tag_out, 5'd12);
    tick();

    // Reset in the middle of a divide, then a normal divide
    start_div = 1'b1; operand_a = 32'd1000; operand_b = 32'd3; tag_in = 5'd13;
    tick();
    start_div = 1'b0;
    repeat (5) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clock);
    check_output("midreset_result", result, 0);
    check_output("midreset_tag", tag_out, 0);
    check_output("midreset_busy", busy, 0);
    tick();
    apply_stimulus(0, 0, 32'd1000, 32'd3, 5'd14, 32'd333, 0, W, "div_after_reset");

    for (int i = 0; i < 2500; i++) begin
      reset      = ($urandom_range(0, 199) != 0);
      flush      = ($urandom_range(0, 59) == 0);
      start_mult = ($urandom_range(0, 3) == 0);
      start_div  = ($urandom_range(0, 3) == 0);
      operand_a  = rand_operand();
      operand_b  = rand_operand();
      tag_in     = 5'($urandom);
      tick();
    end
    reset = 1'b1; flush = 1'b0; start_mult = 1'b0; start_div = 1'b0;
    repeat (W + 4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
